sig_pulse_tx: RTL and testbench

SIG_PULSE_TX -- requirements
Module: sig_pulse_tx

---
 rtl/sig_pulse_tx.sv | 121 ++++++++++++
 tb/tb_sig_pulse_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sig_pulse_tx.sv
// Single-shot pulse transmitter: drives host_o active for W cycles, then enforces an idle gap.
// Optional glitch injection is compiled in with `define SIG_PULSE_GLITCH_INJECT_EN.
module sig_pulse_tx #(
    parameter int unsigned WIDTH_W = 8,
    parameter int unsigned GAP_CYC = 4,
    parameter bit          ACT_LVL = 1'b0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [WIDTH_W-1:0] width,
    output logic               busy,
    output logic               done,
    output logic               host_o
`ifdef SIG_PULSE_GLITCH_INJECT_EN
    ,
    input  logic               glitch,
    input  logic [3:0]         glitch_len
`endif
);

    localparam int unsigned GAP_W    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
    localparam bit          IDLE_LVL = ~ACT_LVL;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
`ifdef SIG_PULSE_GLITCH_INJECT_EN
        ,
        GLITCH
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH_W-1:0] cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               busy_nxt, done_nxt, host_nxt;

    // Outputs are computed from the next state so they are flop outputs aligned with the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            host_o  <= IDLE_LVL;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            host_o  <= host_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PULSE;
                    cnt_nxt   = (width == '0) ? WIDTH_W'(1) : width;
                end
`ifdef SIG_PULSE_GLITCH_INJECT_EN
                else if (glitch && (glitch_len != 4'd0)) begin
                    state_nxt = GLITCH;
                    cnt_nxt   = WIDTH_W'(glitch_len);
                end
`endif
            end
            PULSE: begin
                if (cnt == WIDTH_W'(1)) begin
                    cnt_nxt = '0;
                    if (GAP_CYC == 0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_W'(GAP_CYC);
                    end
                end else begin
                    cnt_nxt = cnt - WIDTH_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
`ifdef SIG_PULSE_GLITCH_INJECT_EN
            // Injected glitch: active for glitch_len cycles, no gap and no done.
            GLITCH: begin
                if (cnt == WIDTH_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - WIDTH_W'(1);
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
`ifdef SIG_PULSE_GLITCH_INJECT_EN
        host_nxt = ((state_nxt == PULSE) || (state_nxt == GLITCH)) ? ACT_LVL : IDLE_LVL;
`else
        host_nxt = (state_nxt == PULSE) ? ACT_LVL : IDLE_LVL;
`endif
    end

endmodule

// File: tb/tb_sig_pulse_tx.sv
// Directed scoreboard bench for sig_pulse_tx (default parameters: ACT_LVL=0, GAP_CYC=4).
module tb_sig_pulse_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] width;
    logic       busy, done, host_o;
`ifdef SIG_PULSE_GLITCH_INJECT_EN
    logic       glitch;
    logic [3:0] glitch_len;
`endif

    typedef struct packed {
        logic host;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    sig_pulse_tx dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .width  (width),
        .busy   (busy),
        .done   (done),
        .host_o (host_o)
`ifdef SIG_PULSE_GLITCH_INJECT_EN
        ,
        .glitch     (glitch),
        .glitch_len (glitch_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue n expected output cycles.
    task automatic push(input logic h, input logic b, input logic d, input int n);
        for (int i = 0; i < n; i++) sb.push_back('{host: h, busy: b, done: d});
    endtask

    // Advance n clocks; after each edge compare the DUT against the next scoreboard entry.
    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
            end else begin
                e = sb.pop_front();
                check("host_o", host_o, e.host);
                check("busy", busy, e.busy);
                check("done", done, e.done);
            end
        end
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b1;
        width = 8'd5;
`ifdef SIG_PULSE_GLITCH_INJECT_EN
        glitch     = 1'b0;
        glitch_len = 4'd0;
`endif
        // Reset with start asserted: held idle.
        push(1'b1, 1'b0, 1'b0, 2);
        run(2);

        // width=5, accepted on the first edge with rstn=1.
        rstn = 1'b1;
        push(1'b0, 1'b1, 1'b0, 5);
        push(1'b1, 1'b1, 1'b0, 4);
        push(1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b0, 1'b0, 1);
        run(1);
        start = 1'b0;
        run(10);

        // width=0 behaves as one active cycle.
        start = 1'b1;
        width = 8'd0;
        push(1'b0, 1'b1, 1'b0, 1);
        push(1'b1, 1'b1, 1'b0, 4);
        push(1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b0, 1'b0, 1);
        run(1);
        start = 1'b0;
        run(6);

        // start held high: each re-accept coincides with the done cycle.
        start = 1'b1;
        width = 8'd3;
        for (int p = 0; p < 3; p++) begin
            push(1'b0, 1'b1, 1'b0, 3);
            push(1'b1, 1'b1, 1'b0, 4);
            push(1'b1, 1'b0, 1'b1, 1);
        end
        run(24);
        start = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1);
        run(1);

        // start pulsed during PULSE and during GAP is dropped.
        width = 8'd4;
        push(1'b0, 1'b1, 1'b0, 4);
        push(1'b1, 1'b1, 1'b0, 4);
        push(1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b0, 1'b0, 2);
        start = 1'b1;
        run(1);
        start = 1'b0;
        run(1);
        start = 1'b1;
        run(1);
        start = 1'b0;
        run(3);
        start = 1'b1;
        run(1);
        start = 1'b0;
        run(4);

        // Reset on the 3rd active cycle of width=10 aborts without done.
        width = 8'd10;
        start = 1'b1;
        push(1'b0, 1'b1, 1'b0, 3);
        push(1'b1, 1'b0, 1'b0, 3);
        run(1);
        start = 1'b0;
        run(2);
        rstn = 1'b0;
        run(1);
        rstn = 1'b1;
        run(2);

        // Maximum width: 255 active cycles without wrap.
        width = 8'd255;
        start = 1'b1;
        push(1'b0, 1'b1, 1'b0, 255);
        push(1'b1, 1'b1, 1'b0, 4);
        push(1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b0, 1'b0, 1);
        run(1);
        start = 1'b0;
        run(260);

`ifdef SIG_PULSE_GLITCH_INJECT_EN
        // Glitch of length 2: active 2 cycles, no gap, no done.
        glitch     = 1'b1;
        glitch_len = 4'd2;
        push(1'b0, 1'b1, 1'b0, 2);
        push(1'b1, 1'b0, 1'b0, 2);
        run(1);
        glitch = 1'b0;
        run(3);
        // glitch_len=0 does nothing.
        glitch     = 1'b1;
        glitch_len = 4'd0;
        push(1'b1, 1'b0, 1'b0, 2);
        run(2);
        // start wins over glitch on the same edge.
        glitch_len = 4'd5;
        start      = 1'b1;
        width      = 8'd1;
        push(1'b0, 1'b1, 1'b0, 1);
        push(1'b1, 1'b1, 1'b0, 4);
        push(1'b1, 1'b0, 1'b1, 1);
        run(1);
        start  = 1'b0;
        glitch = 1'b0;
        run(5);
`endif

        n_cmp++;
        assert (sb.size() === 0) else begin
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
